trigger_capture: RTL and testbench

- Sits directly downstream of the mouse-driven user_interface block.
- Decimates the 12-bit ADC sample stream using the user-set rate and detects a level crossing against the user-set trigger level.
- Stores one frame of DEPTH decimated samples in a dual-port buffer, which the VGA waveform renderer reads by address.
- Provides normal (wait for trigger) and auto (timeout-forced) trigger modes.

---
 rtl/osc_pkg.sv | 8 +
 rtl/sample_ram.sv | 25 ++
 rtl/trigger_capture.sv | 110 +++++++++++
 tb/tb_trigger_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// osc_pkg: shared types and constants for the oscilloscope capture path.
// Provides the capture FSM state type, ADC sample width and default frame/timeout sizes.
package osc_pkg;
    localparam int ADC_W            = 12;
    localparam int DEF_DEPTH        = 1024;
    localparam int DEF_AUTO_TIMEOUT = 6_500_000;
    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, DONE} capture_state_t;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port frame buffer, one write port and one registered read port.
// Ports: clk, i_rst (clears only the read register), i_wr_en/i_wr_addr/i_wr_data write port,
// i_rd_addr in, o_rd_data out one cycle later (old data on same-address read/write).
module sample_ram
    import osc_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [ADC_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ADC_W-1:0]  o_rd_data
);
    logic [ADC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;

    always_ff @(posedge clk)
        o_rd_data <= i_rst ? '0 : r_mem[i_rd_addr];
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: decimates the ADC stream, detects a level crossing and captures one frame.
// Ports: clk, rst (sync, active-high); adc_data/adc_valid sample stream; trigger_level, decim,
// trig_falling, auto_en, rearm controls; rd_addr/rd_data renderer read port;
// frame_ready (DONE), auto_trig (last frame forced by timeout), busy (CAPTURE).
module trigger_capture
    import osc_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  trigger_level,
    input  logic [ADC_W-1:0]  decim,
    input  logic              trig_falling,
    input  logic              auto_en,
    input  logic              rearm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADC_W-1:0]  rd_data,
    output logic              frame_ready,
    output logic              auto_trig,
    output logic              busy
);
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    capture_state_t    r_state, w_state_nx;
    logic [ADC_W-1:0]  r_dec_cnt, r_prev_sample;
    logic              r_prev_ok, r_auto_trig, w_auto_trig_nx;
    logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_nx;
    logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_cnt_nx;
    logic              w_s_vld, w_rise, w_fall, w_hit, w_tmo_max, w_we;
    logic [ADDR_W-1:0] w_waddr;

    assign w_s_vld   = adc_valid && (r_dec_cnt >= decim);
    assign w_rise    = (r_prev_sample < trigger_level) && (adc_data >= trigger_level);
    assign w_fall    = (r_prev_sample > trigger_level) && (adc_data <= trigger_level);
    assign w_hit     = w_s_vld && r_prev_ok && (trig_falling ? w_fall : w_rise);
    // Saturates so a late auto_en still forces a trigger instead of waiting for a wrap.
    assign w_tmo_max = r_tmo_cnt == TMO_W'(AUTO_TIMEOUT - 1);

    always_comb begin
        w_state_nx     = r_state;
        w_wr_ptr_nx    = r_wr_ptr;
        w_auto_trig_nx = r_auto_trig;
        w_tmo_cnt_nx   = '0;
        w_we           = 1'b0;
        w_waddr        = r_wr_ptr[ADDR_W-1:0];
        case (r_state)
            WAIT_TRIG: begin
                w_tmo_cnt_nx = rearm ? '0 : (w_tmo_max ? r_tmo_cnt : r_tmo_cnt + 1'b1);
                if (w_hit) begin
                    w_we           = 1'b1;
                    w_waddr        = '0;
                    w_wr_ptr_nx    = (ADDR_W+1)'(1);
                    w_auto_trig_nx = 1'b0;
                    w_state_nx     = CAPTURE;
                end else if (auto_en && w_tmo_max) begin
                    w_wr_ptr_nx    = '0;
                    w_auto_trig_nx = 1'b1;
                    w_state_nx     = CAPTURE;
                end
            end
            CAPTURE: if (w_s_vld) begin
                w_we        = 1'b1;
                w_wr_ptr_nx = r_wr_ptr + 1'b1;
                w_state_nx  = (r_wr_ptr == (ADDR_W+1)'(DEPTH - 1)) ? DONE : CAPTURE;
            end
            DONE:    w_state_nx = rearm ? WAIT_TRIG : DONE;
            default: w_state_nx = WAIT_TRIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= WAIT_TRIG;
            r_dec_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_tmo_cnt     <= '0;
            r_prev_sample <= '0;
            r_prev_ok     <= 1'b0;
            r_auto_trig   <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_wr_ptr      <= w_wr_ptr_nx;
            r_tmo_cnt     <= w_tmo_cnt_nx;
            r_auto_trig   <= w_auto_trig_nx;
            r_dec_cnt     <= adc_valid ? (w_s_vld ? '0 : r_dec_cnt + 1'b1) : r_dec_cnt;
            r_prev_sample <= w_s_vld ? adc_data : r_prev_sample;
            // A rearm forgets the previous sample so no edge is seen against pre-rearm data.
            r_prev_ok     <= (rearm && r_state != CAPTURE) ? 1'b0 : (w_s_vld | r_prev_ok);
        end
    end

    sample_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .i_rst     (rst),
        .i_wr_en   (w_we),
        .i_wr_addr (w_waddr),
        .i_wr_data (adc_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign busy        = r_state == CAPTURE;
    assign frame_ready = r_state == DONE;
    assign auto_trig   = r_auto_trig;
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: randomized and directed stimulus checked against a behavioural frame model.
module tb_trigger_capture;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   adc_data, trigger_level, decim, rd_data;
    logic          adc_valid, trig_falling, auto_en, rearm;
    logic [AW-1:0] rd_addr;
    logic          frame_ready, auto_trig, busy;

    always #5 clk = ~clk;

    trigger_capture #(.DEPTH(DEPTH), .ADDR_W(AW), .AUTO_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
        .trigger_level(trigger_level), .decim(decim), .trig_falling(trig_falling),
        .auto_en(auto_en), .rearm(rearm), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_ready(frame_ready), .auto_trig(auto_trig), .busy(busy)
    );

    int n_chk = 0, n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 waiting, 1 filling the frame, 2 frame held.
    int m_mode, m_since_keep, m_ptr, m_wait, m_prev, m_rd;
    bit m_prev_ok, m_auto, m_rd_known;
    int m_mem [DEPTH];
    bit m_known [DEPTH];
    bit fix_addr = 1'b0, last_busy = 1'b0;
    int rises = 0;

    task automatic model_write(input int a, input int d);
        m_mem[a]   = d;
        m_known[a] = 1'b1;
    endtask

    task automatic tick();
        int d, lvl, old_mode;
        bit keep, hit;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_since_keep = 0; m_ptr = 0; m_wait = 0; m_prev_ok = 0; m_auto = 0;
            m_rd = 0; m_rd_known = 1;
        end else begin
            m_rd_known = m_known[int'(rd_addr)];
            m_rd       = m_mem[int'(rd_addr)];
            d    = int'(adc_data);
            lvl  = int'(trigger_level);
            keep = adc_valid && (m_since_keep >= int'(decim));
            hit  = keep && m_prev_ok && (trig_falling ? (m_prev > lvl && d <= lvl)
                                                      : (m_prev < lvl && d >= lvl));
            old_mode = m_mode;
            if (m_mode == 0) begin
                if (hit) begin
                    model_write(0, d); m_ptr = 1; m_auto = 0; m_mode = 1;
                end else if (auto_en && m_wait >= TMO - 1) begin
                    m_ptr = 0; m_auto = 1; m_mode = 1;
                end
                m_wait = rearm ? 0 : m_wait + 1;
            end else if (m_mode == 1) begin
                if (keep) begin
                    model_write(m_ptr, d);
                    m_ptr++;
                    if (m_ptr == DEPTH) m_mode = 2;
                end
            end else if (rearm) m_mode = 0;
            if (m_mode != 0 || old_mode != 0) m_wait = 0;
            if (keep) begin m_prev = d; m_prev_ok = 1; end
            if (rearm && old_mode != 1) m_prev_ok = 0;
            if (adc_valid) m_since_keep = keep ? 0 : m_since_keep + 1;
        end
        #1;
        check("busy", int'(busy), int'(m_mode == 1));
        check("frame_ready", int'(frame_ready), int'(m_mode == 2));
        check("auto_trig", int'(auto_trig), int'(m_auto));
        if (m_rd_known) check("rd_data", int'(rd_data), m_rd);
        if (busy && !last_busy) rises++;
        last_busy = busy;
    endtask

    task automatic feed(input bit v, input int d);
        adc_valid = v;
        adc_data  = 12'(d);
        if (!fix_addr) rd_addr = AW'($urandom_range(0, DEPTH - 1));
        tick();
        rearm = 1'b0;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        feed(1'b0, 0);
    endtask

    task automatic read_at(input int a, output int v);
        fix_addr = 1'b1;
        rd_addr  = AW'(a);
        feed(1'b0, 0);
        fix_addr = 1'b0;
        v = int'(rd_data);
    endtask

    initial begin
        int v, k, r, prv, span;
        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; trigger_level = 12'd2048; decim = '0;
        trig_falling = 1'b0; auto_en = 1'b0; rearm = 1'b0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        tick(); tick();
        check("reset_busy", int'(busy), 0);
        check("reset_frame_ready", int'(frame_ready), 0);
        check("reset_auto_trig", int'(auto_trig), 0);
        check("reset_rd_data", int'(rd_data), 0);
        rst = 1'b0;

        // Rising trigger on a ramp with random gaps; a rearm mid-capture must be ignored.
        v = 2000;
        for (int i = 0; i < 20000 && !frame_ready; i++) begin
            if (busy && m_ptr == 300) rearm = 1'b1;
            if ($urandom_range(0, 3) != 0) begin feed(1'b1, v); v = (v + 10) % 4096; end
            else feed(1'b0, 0);
        end
        check("t1_frame_ready", int'(frame_ready), 1);
        read_at(0, r); check("t1_buf0", r, 2050);
        read_at(1, r); check("t1_buf1", r, 2060);
        check("t1_auto_trig", int'(auto_trig), 0);
        do_rearm();
        check("t1_rearm_drop", int'(frame_ready), 0);

        // Decimation by 4 on a counter pattern, trigger forced by timeout.
        decim = 12'd3; trig_falling = 1'b1; trigger_level = 12'd4095; auto_en = 1'b1;
        span = 0;
        for (int c = 0; c < 12000 && !frame_ready; c++) begin
            feed(1'b1, c % 4096);
            if (busy) span++;
        end
        check("t2_frame_ready", int'(frame_ready), 1);
        check("t2_auto_trig", int'(auto_trig), 1);
        check("t2_span", int'(span >= 4093 && span <= 4096), 1);
        read_at(0, prv);
        for (int i = 1; i < DEPTH; i++) begin
            read_at(i, r);
            check("t2_delta", (r - prv + 4096) % 4096, 4);
            prv = r;
        end
        do_rearm();

        // Falling step triggers once; the same step must not fire a rising trigger.
        decim = '0; trigger_level = 12'd2048; trig_falling = 1'b1; auto_en = 1'b0; rises = 0;
        for (int i = 0; i < 20; i++) feed(1'b1, 3000);
        for (int i = 0; i < 3000 && !frame_ready; i++) feed(1'b1, 1000);
        check("t3_triggers", rises, 1);
        check("t3_auto_trig", int'(auto_trig), 0);
        read_at(0, r); check("t3_buf0", r, 1000);
        trig_falling = 1'b0;
        do_rearm();
        rises = 0;
        for (int i = 0; i < 20; i++) feed(1'b1, 3000);
        for (int i = 0; i < 200; i++) feed(1'b1, 1000);
        check("t3_no_rise_trigger", rises, 0);
        check("t3_still_waiting", int'(busy | frame_ready), 0);

        // Auto timeout after exactly TMO cycles, then none with auto_en low.
        do_rearm();
        auto_en = 1'b1; k = 0;
        while (!busy && k < 1000) begin feed(1'b1, 500); k++; end
        check("t4_timeout_cycles", k, TMO);
        check("t4_auto_trig", int'(auto_trig), 1);
        for (int i = 0; i < 3000 && !frame_ready; i++) feed(1'b1, 500);
        check("t4_frame_ready", int'(frame_ready), 1);
        auto_en = 1'b0;
        do_rearm();
        rises = 0;
        for (int i = 0; i < 300; i++) feed(1'b1, 500);
        check("t4_no_auto", rises, 0);

        // Reset in the middle of a capture, then a fresh trigger writes address 0.
        v = 2000;
        for (int i = 0; i < 3000 && !(m_mode == 1 && m_ptr == 500); i++) begin
            feed(1'b1, v); v = (v + 10) % 4096;
        end
        check("t5_reached_500", m_ptr, 500);
        rst = 1'b1; feed(1'b0, 0); rst = 1'b0;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_frame_ready", int'(frame_ready), 0);
        v = 2000;
        for (int i = 0; i < 3000 && !frame_ready; i++) begin
            feed(1'b1, v); v = (v + 10) % 4096;
        end
        read_at(0, r); check("t5_buf0", r, 2050);

        // Edge on the same cycle the timeout expires: the edge wins.
        do_rearm();
        auto_en = 1'b1;
        for (int j = 1; j < TMO; j++) feed(1'b1, 1000);
        feed(1'b1, 3000);
        check("t6_tie_busy", int'(busy), 1);
        check("t6_tie_auto_trig", int'(auto_trig), 0);
        for (int i = 0; i < 3000 && !frame_ready; i++) feed(1'b1, 3000);
        read_at(0, r); check("t6_buf0", r, 3000);

        // Random frames: random decimation, level, polarity, timeout and sample gaps.
        for (int n = 0; n < 4; n++) begin
            do_rearm();
            decim         = 12'($urandom_range(0, 2));
            trigger_level = 12'($urandom_range(500, 3500));
            trig_falling  = 1'($urandom_range(0, 1));
            auto_en       = 1'($urandom_range(0, 1));
            for (int i = 0; i < 20000 && !frame_ready; i++)
                feed(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
            check("rand_frame_ready", int'(frame_ready), 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
